// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/seq_mul_datapath.sv
// Multiplicand/product registers and one shift-add step per cycle.
module seq_mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum     = {1'b0, product_q[2*WIDTH-1:WIDTH]}
                + (product_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        shifted = {sum, product_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            product_q <= '0;
        end else if (load) begin
            mcand_q   <= mcand_in;
            product_q <= {{WIDTH{1'b0}}, mplier_in};
        end else if (step) begin
            product_q <= shifted;
        end
    end

    assign product = product_q;

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential MULT/MULTU unit with start/busy/done handshake and HI/LO outputs.
// Signed MULT support is compiled in only when SEQ_MUL_SIGNED_EN is defined.
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               negate_q;
    logic               sign_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;
    logic               load;
    logic               step;
    logic               last_cycle;

`ifdef SEQ_MUL_SIGNED_EN
    // The most negative value negates to itself, which read unsigned is its magnitude.
    always_comb begin
        mag_a     = (signed_op & a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
        mag_b     = (signed_op & b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
        sign_next = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    assign result = negate_q ? (~product + {{(2*WIDTH-1){1'b0}}, 1'b1}) : product;
`else
    always_comb begin
        mag_a     = a;
        mag_b     = b;
        sign_next = signed_op & 1'b0;
    end

    assign result = negate_q ? product : product;
`endif

    assign last_cycle = (cnt == CNT_W'(WIDTH));
    assign load       = (state == IDLE) && start;
    assign step       = (state == RUN) && !last_cycle;

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .mcand_in  (mag_a),
        .mplier_in (mag_b),
        .product   (product)
    );

    // Counter runs 0..WIDTH; the RUN cycle at WIDTH does no shift and loads hi/lo.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            negate_q <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        negate_q <= sign_next;
                    end
                end
                RUN: begin
                    if (last_cycle) begin
                        state    <= FIN;
                        done     <= 1'b1;
                        hi       <= result[2*WIDTH-1:WIDTH];
                        lo       <= result[WIDTH-1:0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed self-checking bench for seq_mul_unit at WIDTH=32 and WIDTH=8.
module tb_seq_mul_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8 = 1'b0;
    logic        signed8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mul_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    seq_mul_unit #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .signed_op (signed8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .hi        (hi8),
        .lo        (lo8)
    );

    // Issues one operation and watches 40 cycles; lat is edges from the sampling edge to done.
    task automatic run_op32(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                            output logic [31:0] ohi, output logic [31:0] olo,
                            output int lat, output int busy_cycles, output int dones);
        a = ia;
        b = ib;
        signed_op = is;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1357_9BDF;
        lat = -1;
        busy_cycles = 0;
        dones = 0;
        ohi = '0;
        olo = '0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                dones++;
                lat = i;
                ohi = hi;
                olo = lo;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a = 32'd3;
        b = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b expected busy=0 done=0", busy, done);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", hi, lo);
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_start_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_multu_max();
        logic [31:0] rh, rl;
        int lat, bc, nd;
        run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, lat, bc, nd);
        checks++;
        if (rh !== 32'hFFFF_FFFE || rl !== 32'h0000_0001) begin
            failures++;
            $display("[TB] FAIL multu_max: got %h_%h expected fffffffe_00000001", rh, rl);
        end
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("[TB] FAIL multu_latency: got %0d expected 33", lat);
        end
        checks++;
        if (nd !== 1) begin
            failures++;
            $display("[TB] FAIL multu_done_pulses: got %0d expected 1", nd);
        end
        checks++;
        if (bc !== 34) begin
            failures++;
            $display("[TB] FAIL multu_busy_cycles: got %0d expected 34", bc);
        end
    endtask

    task automatic test_signed();
        logic [31:0] rh, rl;
        logic [63:0] exp_m3x5, exp_minmin, exp_m1m1, exp_6xm7;
        int lat, bc, nd;
`ifdef SEQ_MUL_SIGNED_EN
        exp_m3x5   = 64'hFFFF_FFFF_FFFF_FFF1;
        exp_minmin = 64'h4000_0000_0000_0000;
        exp_m1m1   = 64'h0000_0000_0000_0001;
        exp_6xm7   = 64'hFFFF_FFFF_FFFF_FFD6;
`else
        exp_m3x5   = 64'h0000_0004_FFFF_FFF1;
        exp_minmin = 64'h4000_0000_0000_0000;
        exp_m1m1   = 64'hFFFF_FFFE_0000_0001;
        exp_6xm7   = 64'h0000_0005_FFFF_FFD6;
`endif
        run_op32(32'hFFFF_FFFD, 32'd5, 1'b1, rh, rl, lat, bc, nd);
        checks++;
        if ({rh, rl} !== exp_m3x5 || nd !== 1) begin
            failures++;
            $display("[TB] FAIL signed_m3x5: got %h_%h (dones=%0d) expected %h", rh, rl, nd, exp_m3x5);
        end
        run_op32(32'h8000_0000, 32'h8000_0000, 1'b1, rh, rl, lat, bc, nd);
        checks++;
        if ({rh, rl} !== exp_minmin || nd !== 1) begin
            failures++;
            $display("[TB] FAIL signed_minmin: got %h_%h (dones=%0d) expected %h", rh, rl, nd, exp_minmin);
        end
        run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, rh, rl, lat, bc, nd);
        checks++;
        if ({rh, rl} !== exp_m1m1 || nd !== 1) begin
            failures++;
            $display("[TB] FAIL signed_m1m1: got %h_%h (dones=%0d) expected %h", rh, rl, nd, exp_m1m1);
        end
        run_op32(32'd6, 32'hFFFF_FFF9, 1'b1, rh, rl, lat, bc, nd);
        checks++;
        if ({rh, rl} !== exp_6xm7 || nd !== 1) begin
            failures++;
            $display("[TB] FAIL signed_6xm7: got %h_%h (dones=%0d) expected %h", rh, rl, nd, exp_6xm7);
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        logic [31:0] rh, rl;
        a = 32'd7;
        b = 32'd6;
        signed_op = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        rh = '0;
        rl = '0;
        for (int i = 0; i < 34; i++) begin
            if (done) begin
                nd++;
                rh = hi;
                rl = lo;
            end
            if (i == 5) begin
                start = 1'b1;
                a = 32'd3;
                b = 32'd3;
            end else if (i == 33) begin
                start = 1'b1;
                a = 32'd100;
                b = 32'd100;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (nd !== 1 || rl !== 32'd42 || rh !== 32'd0) begin
            failures++;
            $display("[TB] FAIL b2b_first: dones=%0d got %h_%h expected 1 done of 0_0000002a", nd, rh, rl);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_fin_start_ignored: busy=%b expected 0", busy);
        end
        a = 32'd2;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_accept: busy=%b expected 1", busy);
        end
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                nd++;
                rl = lo;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (nd !== 1 || rl !== 32'd18) begin
            failures++;
            $display("[TB] FAIL b2b_second: dones=%0d lo=%h expected 1 done with 00000012", nd, rl);
        end
    endtask

    task automatic test_reset_mid();
        int nd, lat, bc;
        logic [31:0] rh, rl;
        a = 32'h1234;
        b = 32'h5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid: busy=%b done=%b hilo=%h_%h expected 0 0 0_0", busy, done, hi, lo);
        end
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) nd++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_no_done: active cycles=%0d expected 0", nd);
        end
        run_op32(32'h0001_0000, 32'h0001_0000, 1'b0, rh, rl, lat, bc, nd);
        checks++;
        if (rh !== 32'd1 || rl !== 32'd0 || nd !== 1) begin
            failures++;
            $display("[TB] FAIL after_reset_op: got %h_%h dones=%0d expected 00000001_00000000", rh, rl, nd);
        end
    endtask

    task automatic test_width8();
        int lat, nd;
        logic [7:0] rh, rl;
        a8 = 8'hFF;
        b8 = 8'hFF;
        signed8 = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = -1;
        nd = 0;
        rh = '0;
        rl = '0;
        for (int i = 0; i < 16; i++) begin
            if (done8) begin
                nd++;
                lat = i;
                rh = hi8;
                rl = lo8;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rh !== 8'hFE || rl !== 8'h01 || nd !== 1) begin
            failures++;
            $display("[TB] FAIL w8_ffxff: got %h_%h dones=%0d expected fe_01", rh, rl, nd);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("[TB] FAIL w8_latency: got %0d expected 9", lat);
        end
        a8 = 8'd12;
        b8 = 8'd11;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        nd = 0;
        for (int i = 0; i < 16; i++) begin
            if (done8) begin
                nd++;
                rh = hi8;
                rl = lo8;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rh !== 8'h00 || rl !== 8'h84 || nd !== 1) begin
            failures++;
            $display("[TB] FAIL w8_12x11: got %h_%h dones=%0d expected 00_84", rh, rl, nd);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
